multicycle_control_unit: RTL and testbench

Main control FSM for the multicycle MIPS datapath. It sequences one instruction at a time through fetch, decode, execute, memory and writeback. Each cycle it drives every datapath select and write-enable, including the 2-bit ALU source-B selector of the 4:1 operand mux. It sits beside the datapath, takes the opcode from the instruction register, and handshakes with the unified instruction/data memory.

---
 rtl/multicycle_control_unit_pkg.sv | 61 ++++++
 rtl/multicycle_control_unit_control_output_decoder.sv | 73 +++++++
 rtl/multicycle_control_unit.sv | 92 +++++++++
 tb/tb_multicycle_control_unit.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, FSM states,
// datapath mux selects and the control word driven every cycle.
package multicycle_control_unit_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_MEM_WB  = 4'd4,
    S_MEM_WR  = 4'd5,
    S_EXEC    = 4'd6,
    S_ALU_WB  = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDI_EX = 4'd9,
    S_ADDI_WB = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       pc_write_cond;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/multicycle_control_unit_control_output_decoder.sv
// Combinational decode of the FSM state into the datapath control word.
// Reset low shows FETCH selects with every enable held off.
module control_output_decoder
  import multicycle_control_unit_pkg::*;
(
  input  logic [3:0] state,
  input  logic       mem_ready,
  input  logic       reset,
  output ctrl_t      ctrl
);

  logic [3:0] sel;

  always_comb begin
    sel  = reset ? state : S_FETCH;
    ctrl = '0;
    case (sel)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE:  ctrl.alu_src_b = SRCB_IMM_SH2;
      S_MEM_ADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        ctrl.iord     = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALU_WB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.pc_write_cond = 1'b1;
      end
      S_ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_ADDI_WB: ctrl.reg_write = 1'b1;
      S_JUMP: begin
        ctrl.pc_source = PCSRC_JUMP;
        ctrl.pc_write  = 1'b1;
      end
      default: ;
    endcase
    if (!reset) begin
      ctrl.ir_write = 1'b0;
      ctrl.pc_write = 1'b0;
      ctrl.mem_read = 1'b0;
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Main multicycle MIPS control FSM: sequences fetch/decode/execute/memory/
// writeback and drives every datapath select and enable each cycle.
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int USE_MEM_READY = 1,
  parameter int STATE_WIDTH   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [5:0]             opcode,
  input  logic                   mem_ready,
  output logic                   iord,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   ir_write,
  output logic                   reg_dst,
  output logic                   mem_to_reg,
  output logic                   reg_write,
  output logic                   alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [1:0]             alu_op,
  output logic [1:0]             pc_source,
  output logic                   pc_write,
  output logic                   pc_write_cond,
  output logic                   illegal_op,
  output logic [STATE_WIDTH-1:0] state_o
);

  // Raw 4-bit register so the unused codes 12-15 stay representable.
  logic [3:0] state;
  logic       ready;
  ctrl_t      ctrl;

  assign ready = (USE_MEM_READY != 0) ? mem_ready : 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:   state <= ready ? S_DECODE : S_FETCH;
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW: state <= S_MEM_ADR;
            OP_R:         state <= S_EXEC;
            OP_BEQ:       state <= S_BRANCH;
            OP_ADDI:      state <= S_ADDI_EX;
            OP_J:         state <= S_JUMP;
            default:      state <= S_FETCH;
          endcase
        end
        S_MEM_ADR: state <= (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD:  state <= ready ? S_MEM_WB : S_MEM_RD;
        S_MEM_WB:  state <= S_FETCH;
        S_MEM_WR:  state <= ready ? S_FETCH : S_MEM_WR;
        S_EXEC:    state <= S_ALU_WB;
        S_ALU_WB:  state <= S_FETCH;
        S_BRANCH:  state <= S_FETCH;
        S_ADDI_EX: state <= S_ADDI_WB;
        S_ADDI_WB: state <= S_FETCH;
        S_JUMP:    state <= S_FETCH;
        default:   state <= S_FETCH;
      endcase
    end
  end

  control_output_decoder u_decoder (
    .state     (state),
    .mem_ready (ready),
    .reset     (reset),
    .ctrl      (ctrl)
  );

  assign iord          = ctrl.iord;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign reg_dst       = ctrl.reg_dst;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;

  assign illegal_op = reset && (state == S_DECODE) && !is_legal_op(opcode);
  assign state_o    = reset ? STATE_WIDTH'(state) : '0;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: walks each instruction class,
// memory wait states, an illegal opcode and a mid-store reset.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg;
  logic       reg_write, alu_src_a, pc_write, pc_write_cond, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state_o;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  multicycle_control_unit #(.USE_MEM_READY(1), .STATE_WIDTH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .illegal_op    (illegal_op),
    .state_o       (state_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic enables_off(input string tag);
    check({tag, "_wen"}, {28'd0, pc_write, pc_write_cond, ir_write, reg_write}, 32'd0);
    check({tag, "_men"}, {29'd0, mem_write, mem_read, illegal_op}, 32'd0);
  endtask

  initial begin
    reset     = 1'b0;
    opcode    = 6'b000000;
    mem_ready = 1'b1;

    // Reset held three cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_state", state_o, 32'd0);
      enables_off("rst");
    end
    reset = 1'b1;
    #1;
    check("rel_state", state_o, 32'd0);
    check("rel_irw", ir_write, 32'd1);
    check("rel_pcw", pc_write, 32'd1);
    check("rel_srcb", alu_src_b, 32'd1);
    check("rel_mrd", mem_read, 32'd1);

    // R-type: 0,1,6,7,0
    tick(); check("r_s1", state_o, 32'd1);
    check("dec_srcb", alu_src_b, 32'd3);
    tick(); check("r_s6", state_o, 32'd6);
    check("exec_srcb", alu_src_b, 32'd0);
    check("exec_aluop", alu_op, 32'd2);
    check("exec_srca", alu_src_a, 32'd1);
    tick(); check("r_s7", state_o, 32'd7);
    check("alwb_rw", reg_write, 32'd1);
    check("alwb_rd", reg_dst, 32'd1);
    tick(); check("r_s0", state_o, 32'd0);

    // LW with two wait cycles in MEM_RD: 0,1,2,3,3,3,4,0
    opcode = 6'b100011;
    tick(); check("lw_s1", state_o, 32'd1);
    tick(); check("lw_s2", state_o, 32'd2);
    check("madr_srcb", alu_src_b, 32'd2);
    tick(); check("lw_s3a", state_o, 32'd3);
    mem_ready = 1'b0;
    #1;
    check("mrd_rd", mem_read, 32'd1);
    check("mrd_iord", iord, 32'd1);
    tick(); check("lw_s3b", state_o, 32'd3);
    check("mrd_rd_hold", {iord, mem_read}, 32'd3);
    tick(); check("lw_s3c", state_o, 32'd3);
    mem_ready = 1'b1;
    tick(); check("lw_s4", state_o, 32'd4);
    check("mwb_m2r", mem_to_reg, 32'd1);
    check("mwb_rw", reg_write, 32'd1);
    check("mwb_rd", reg_dst, 32'd0);
    tick(); check("lw_s0", state_o, 32'd0);

    // Wait state in FETCH: IR and PC must not load
    mem_ready = 1'b0;
    #1;
    check("fw_irw", ir_write, 32'd0);
    check("fw_pcw", pc_write, 32'd0);
    tick(); check("fw_hold", state_o, 32'd0);
    mem_ready = 1'b1;

    // BEQ: 0,1,8,0
    opcode = 6'b000100;
    tick(); check("beq_s1", state_o, 32'd1);
    check("beq_dec_srcb", alu_src_b, 32'd3);
    tick(); check("beq_s8", state_o, 32'd8);
    check("br_pwc", pc_write_cond, 32'd1);
    check("br_pcsrc", pc_source, 32'd1);
    check("br_aluop", alu_op, 32'd1);
    check("br_pcw", pc_write, 32'd0);
    tick(); check("beq_s0", state_o, 32'd0);

    // J: 0,1,11,0
    opcode = 6'b000010;
    tick(); check("j_s1", state_o, 32'd1);
    tick(); check("j_s11", state_o, 32'd11);
    check("j_pcw", pc_write, 32'd1);
    check("j_pcsrc", pc_source, 32'd2);
    tick(); check("j_s0", state_o, 32'd0);

    // ADDI: 0,1,9,10,0
    opcode = 6'b001000;
    tick(); check("ad_s1", state_o, 32'd1);
    tick(); check("ad_s9", state_o, 32'd9);
    check("adex_srcb", alu_src_b, 32'd2);
    tick(); check("ad_s10", state_o, 32'd10);
    check("adwb_ctl", {reg_write, reg_dst, mem_to_reg}, 32'h4);
    tick(); check("ad_s0", state_o, 32'd0);

    // Illegal opcode: 0,1,0 with a single illegal_op pulse
    opcode = 6'b111111;
    check("ill_pre", illegal_op, 32'd0);
    tick(); check("ill_s1", state_o, 32'd1);
    check("ill_pulse", illegal_op, 32'd1);
    check("ill_nowr", {reg_write, mem_write}, 32'd0);
    tick(); check("ill_s0", state_o, 32'd0);
    check("ill_gone", illegal_op, 32'd0);
    check("ill_nowr2", {reg_write, mem_write}, 32'd0);

    // SW aborted by reset while stalled in MEM_WR
    opcode = 6'b101011;
    tick(); check("sw_s1", state_o, 32'd1);
    tick(); check("sw_s2", state_o, 32'd2);
    tick(); check("sw_s5", state_o, 32'd5);
    mem_ready = 1'b0;
    #1;
    check("mwr_ctl", {iord, mem_write, mem_read}, 32'h6);
    tick(); check("sw_s5_hold", state_o, 32'd5);
    reset = 1'b0;
    #1;
    check("swrst_mw", mem_write, 32'd0);
    check("swrst_state", state_o, 32'd0);
    tick();
    check("swrst_state2", state_o, 32'd0);
    enables_off("swrst");
    reset     = 1'b1;
    opcode    = 6'b000000;
    #1;
    check("swrel_state", state_o, 32'd0);
    check("swrel_mw", mem_write, 32'd0);
    check("swrel_mrd", {iord, mem_read}, 32'd1);
    mem_ready = 1'b1;
    tick(); check("swrel_s1", state_o, 32'd1);
    check("swrel_mw2", mem_write, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
